// File: rtl/fft_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_mem_pkg
// Brief    : Shared constants and types for the FFT data SRAM port sharing.
// Revision : 1.0 - initial release
// ============================================================================
package fft_mem_pkg;

    localparam int SRAM_AW = 8;
    localparam int SRAM_DW = 128;

    // Bit write enables are active low, so all ones means "write nothing".
    localparam logic [SRAM_DW-1:0] BWEB_NONE = {SRAM_DW{1'b1}};

    // Encodings double as grant-vector indices: bit 0 = scan, bit 1 = FFT.
    typedef enum logic {
        OWN_SCAN = 1'b0,
        OWN_FFT  = 1'b1
    } mem_owner_t;

endpackage : fft_mem_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin arbiter with FFT lock override. Grant is
//            combinational; the last-winner pointer is registered.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import fft_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lock,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    mem_owner_t r_last_own;
    mem_owner_t w_winner;
    logic       w_any;

    // Pick the winner: sole requester wins; on conflict lock forces FFT,
    // otherwise whoever did not win last time goes next.
    always_comb begin
        w_winner = r_last_own;
        w_any    = 1'b0;
        case (req)
            2'b01: begin
                w_winner = OWN_SCAN;
                w_any    = 1'b1;
            end
            2'b10: begin
                w_winner = OWN_FFT;
                w_any    = 1'b1;
            end
            2'b11: begin
                w_any = 1'b1;
                if (lock) begin
                    w_winner = OWN_FFT;
                end else if (r_last_own == OWN_FFT) begin
                    w_winner = OWN_SCAN;
                end else begin
                    w_winner = OWN_FFT;
                end
            end
            default: begin
                w_winner = r_last_own;
                w_any    = 1'b0;
            end
        endcase
    end

    // Expand the winner into a one-hot grant vector.
    always_comb begin
        gnt = 2'b00;
        if (w_any) begin
            gnt = (w_winner == OWN_FFT) ? 2'b10 : 2'b01;
        end
    end

    // Remember every winner, lock grants included, so fairness resumes cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_own <= OWN_FFT;
        end else if (w_any) begin
            r_last_own <= w_winner;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Brief    : Shares the single-port FFT data SRAM between the scan path and
//            the FFT engine; routes read data back to the issuing requester
//            and counts denied-request cycles for debug.
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter
    import fft_mem_pkg::*;
#(
    parameter int AW = SRAM_AW,
    parameter int DW = SRAM_DW,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fft_lock,
    input  logic          scan_req,
    input  logic          scan_we,
    input  logic [AW-1:0] scan_addr,
    input  logic [DW-1:0] scan_wdata,
    input  logic [DW-1:0] scan_bweb,
    output logic          scan_gnt,
    output logic          scan_rvalid,
    output logic [DW-1:0] scan_rdata,
    input  logic          fft_req,
    input  logic          fft_we,
    input  logic [AW-1:0] fft_addr,
    input  logic [DW-1:0] fft_wdata,
    output logic          fft_gnt,
    output logic          fft_rvalid,
    output logic [DW-1:0] fft_rdata,
    output logic          sram_ren,
    output logic          sram_wen,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    output logic [DW-1:0] sram_bweb,
    input  logic [DW-1:0] sram_rdata,
    input  logic          conflict_clr,
    output logic [CW-1:0] conflict_cnt
);

    localparam logic [DW-1:0] c_bweb_none = {DW{1'b1}};
    localparam logic [CW-1:0] c_cnt_max   = {CW{1'b1}};
    localparam logic [CW-1:0] c_cnt_one   = {{(CW-1){1'b0}}, 1'b1};

    logic [1:0]    w_gnt;
    logic          w_denied;
    logic          r_rd_pend;
    mem_owner_t    r_rd_own;
    logic [CW-1:0] r_cnt;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .lock  (fft_lock),
        .req   ({fft_req, scan_req}),
        .gnt   (w_gnt)
    );

    assign scan_gnt = w_gnt[0];
    assign fft_gnt  = w_gnt[1];

    // Steer the winner onto the SRAM pins; idle drives a harmless no-op.
    always_comb begin
        sram_ren   = 1'b0;
        sram_wen   = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        sram_bweb  = c_bweb_none;
        if (scan_gnt) begin
            sram_addr = scan_addr;
            if (scan_we) begin
                sram_wen   = 1'b1;
                sram_wdata = scan_wdata;
                sram_bweb  = scan_bweb;
            end else begin
                sram_ren = 1'b1;
            end
        end else if (fft_gnt) begin
            sram_addr = fft_addr;
            if (fft_we) begin
                sram_wen   = 1'b1;
                sram_wdata = fft_wdata;
                sram_bweb  = '0;
            end else begin
                sram_ren = 1'b1;
            end
        end
    end

    // Tag each issued read with its owner so the returning line goes home.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pend <= 1'b0;
            r_rd_own  <= OWN_FFT;
        end else begin
            r_rd_pend <= sram_ren;
            if (sram_ren) begin
                r_rd_own <= scan_gnt ? OWN_SCAN : OWN_FFT;
            end
        end
    end

    assign scan_rvalid = r_rd_pend && (r_rd_own == OWN_SCAN);
    assign fft_rvalid  = r_rd_pend && (r_rd_own == OWN_FFT);
    assign scan_rdata  = scan_rvalid ? sram_rdata : '0;
    assign fft_rdata   = fft_rvalid  ? sram_rdata : '0;

    assign w_denied = (scan_req && !scan_gnt) || (fft_req && !fft_gnt);

    // Saturating debug count of denied cycles; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (conflict_clr) begin
            r_cnt <= '0;
        end else if (w_denied && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    assign conflict_cnt = r_cnt;

endmodule : sram_port_arbiter
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Brief    : Directed self-checking bench for sram_port_arbiter with a small
//            behavioural SRAM model behind it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 128;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fft_lock;
    logic          scan_req, scan_we;
    logic [AW-1:0] scan_addr;
    logic [DW-1:0] scan_wdata, scan_bweb;
    logic          scan_gnt, scan_rvalid;
    logic [DW-1:0] scan_rdata;
    logic          fft_req, fft_we;
    logic [AW-1:0] fft_addr;
    logic [DW-1:0] fft_wdata;
    logic          fft_gnt, fft_rvalid;
    logic [DW-1:0] fft_rdata;
    logic          sram_ren, sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_bweb;
    logic [DW-1:0] sram_rdata;
    logic          conflict_clr;
    logic [CW-1:0] conflict_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fft_lock     (fft_lock),
        .scan_req     (scan_req),
        .scan_we      (scan_we),
        .scan_addr    (scan_addr),
        .scan_wdata   (scan_wdata),
        .scan_bweb    (scan_bweb),
        .scan_gnt     (scan_gnt),
        .scan_rvalid  (scan_rvalid),
        .scan_rdata   (scan_rdata),
        .fft_req      (fft_req),
        .fft_we       (fft_we),
        .fft_addr     (fft_addr),
        .fft_wdata    (fft_wdata),
        .fft_gnt      (fft_gnt),
        .fft_rvalid   (fft_rvalid),
        .fft_rdata    (fft_rdata),
        .sram_ren     (sram_ren),
        .sram_wen     (sram_wen),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_bweb    (sram_bweb),
        .sram_rdata   (sram_rdata),
        .conflict_clr (conflict_clr),
        .conflict_cnt (conflict_cnt)
    );

    // SRAM model: unwritten lines read back as the address byte replicated.
    logic [DW-1:0] mem       [0:255];
    bit            mem_valid [0:255];

    function automatic logic [DW-1:0] init_line(input logic [AW-1:0] a);
        return {16{a}};
    endfunction

    always @(posedge clk) begin
        if (sram_wen) begin
            mem[sram_addr] <= ((mem_valid[sram_addr] ? mem[sram_addr] : init_line(sram_addr)) & sram_bweb)
                              | (sram_wdata & ~sram_bweb);
            mem_valid[sram_addr] <= 1'b1;
        end
        if (sram_ren) begin
            sram_rdata <= mem_valid[sram_addr] ? mem[sram_addr] : init_line(sram_addr);
        end
    end

    task automatic drive_idle();
        fft_lock = 0; scan_req = 0; scan_we = 0; scan_addr = '0; scan_wdata = '0;
        scan_bweb = '1; fft_req = 0; fft_we = 0; fft_addr = '0; fft_wdata = '0;
        conflict_clr = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (scan_gnt !== 1'b0 || fft_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %b%b expected 00", scan_gnt, fft_gnt); end
        n_checks++; if (scan_rvalid !== 1'b0 || fft_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b%b expected 00", scan_rvalid, fft_rvalid); end
        n_checks++; if (conflict_cnt !== 4'h0) begin n_fail++; $display("FAIL rst_cnt: got %h expected 0", conflict_cnt); end
        n_checks++; if (sram_ren !== 1'b0 || sram_wen !== 1'b0 || sram_addr !== 8'h00 || sram_wdata !== '0 || sram_bweb !== {DW{1'b1}}) begin
            n_fail++; $display("FAIL rst_idle: got ren=%b wen=%b addr=%h bweb=%h", sram_ren, sram_wen, sram_addr, sram_bweb); end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_scan_write_read();
        logic [DW-1:0] exp_line;
        logic [DW-1:0] exp_bweb;
        exp_bweb = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
        exp_line = {32'h1212_1212, 32'h1212_1212, 32'hDEAD_BEEF, 32'h1212_1212};
        scan_req = 1; scan_we = 1; scan_addr = 8'h12;
        scan_wdata = {32'h5555_5555, 32'h5555_5555, 32'hDEAD_BEEF, 32'h5555_5555};
        scan_bweb = exp_bweb;
        @(negedge clk);
        n_checks++; if (scan_gnt !== 1'b1) begin n_fail++; $display("FAIL sw_gnt: got %b expected 1", scan_gnt); end
        n_checks++; if (sram_wen !== 1'b1 || sram_ren !== 1'b0 || sram_addr !== 8'h12) begin
            n_fail++; $display("FAIL sw_strobe: got wen=%b ren=%b addr=%h expected 1 0 12", sram_wen, sram_ren, sram_addr); end
        n_checks++; if (sram_bweb !== exp_bweb) begin n_fail++; $display("FAIL sw_bweb: got %h expected %h", sram_bweb, exp_bweb); end
        next_cycle();
        scan_we = 0;
        @(negedge clk);
        n_checks++; if (scan_gnt !== 1'b1 || sram_ren !== 1'b1 || sram_wen !== 1'b0) begin
            n_fail++; $display("FAIL sr_strobe: got gnt=%b ren=%b wen=%b expected 1 1 0", scan_gnt, sram_ren, sram_wen); end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_checks++; if (scan_rvalid !== 1'b1 || scan_rdata !== exp_line) begin
            n_fail++; $display("FAIL sr_data: got v=%b d=%h expected 1 %h", scan_rvalid, scan_rdata, exp_line); end
        n_checks++; if (fft_rvalid !== 1'b0 || fft_rdata !== '0) begin
            n_fail++; $display("FAIL sr_fft_quiet: got v=%b d=%h expected 0 0", fft_rvalid, fft_rdata); end
        next_cycle();
    endtask

    task automatic test_fairness();
        logic exp_scan;
        logic prev_scan;
        apply_reset();
        scan_req = 1; scan_addr = 8'h20; fft_req = 1; fft_addr = 8'h21;
        for (int k = 0; k < 6; k++) begin
            exp_scan = ((k % 2) == 0);
            @(negedge clk);
            n_checks++; if (scan_gnt !== exp_scan || fft_gnt !== !exp_scan) begin
                n_fail++; $display("FAIL fair_gnt[%0d]: got s=%b f=%b expected s=%b", k, scan_gnt, fft_gnt, exp_scan); end
            if (k > 0) begin
                n_checks++; if (scan_rvalid !== prev_scan || fft_rvalid !== !prev_scan) begin
                    n_fail++; $display("FAIL fair_rv[%0d]: got s=%b f=%b expected s=%b", k, scan_rvalid, fft_rvalid, prev_scan); end
            end
            prev_scan = exp_scan;
            next_cycle();
        end
        drive_idle();
        @(negedge clk);
        n_checks++; if (fft_rvalid !== 1'b1 || fft_rdata !== {16{8'h21}}) begin
            n_fail++; $display("FAIL fair_last: got v=%b d=%h expected 1 %h", fft_rvalid, fft_rdata, {16{8'h21}}); end
        n_checks++; if (conflict_cnt !== 4'd6) begin n_fail++; $display("FAIL fair_cnt: got %0d expected 6", conflict_cnt); end
        next_cycle();
    endtask

    task automatic test_lock();
        conflict_clr = 1;
        next_cycle();
        conflict_clr = 0;
        fft_lock = 1; scan_req = 1; scan_addr = 8'h40; fft_req = 1; fft_addr = 8'h41;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (fft_gnt !== 1'b1 || scan_gnt !== 1'b0) begin
                n_fail++; $display("FAIL lock_gnt[%0d]: got s=%b f=%b expected s=0 f=1", k, scan_gnt, fft_gnt); end
            next_cycle();
        end
        fft_lock = 0;
        @(negedge clk);
        n_checks++; if (scan_gnt !== 1'b1 || fft_gnt !== 1'b0) begin
            n_fail++; $display("FAIL lock_release: got s=%b f=%b expected s=1 f=0", scan_gnt, fft_gnt); end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_checks++; if (conflict_cnt !== 4'd5) begin n_fail++; $display("FAIL lock_cnt: got %0d expected 5", conflict_cnt); end
        next_cycle();
    endtask

    task automatic test_read_routing();
        fft_req = 1; fft_addr = 8'h01;
        @(negedge clk);
        n_checks++; if (fft_gnt !== 1'b1 || sram_ren !== 1'b1 || sram_addr !== 8'h01) begin
            n_fail++; $display("FAIL rr_issue: got g=%b ren=%b addr=%h expected 1 1 01", fft_gnt, sram_ren, sram_addr); end
        next_cycle();
        fft_req = 0; scan_req = 1; scan_addr = 8'h02;
        @(negedge clk);
        n_checks++; if (fft_rvalid !== 1'b1 || fft_rdata !== {16{8'h01}}) begin
            n_fail++; $display("FAIL rr_fft: got v=%b d=%h expected 1 %h", fft_rvalid, fft_rdata, {16{8'h01}}); end
        n_checks++; if (scan_rvalid !== 1'b0 || scan_rdata !== '0 || scan_gnt !== 1'b1) begin
            n_fail++; $display("FAIL rr_scan_quiet: got v=%b d=%h g=%b expected 0 0 1", scan_rvalid, scan_rdata, scan_gnt); end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_checks++; if (scan_rvalid !== 1'b1 || scan_rdata !== {16{8'h02}}) begin
            n_fail++; $display("FAIL rr_scan: got v=%b d=%h expected 1 %h", scan_rvalid, scan_rdata, {16{8'h02}}); end
        n_checks++; if (fft_rvalid !== 1'b0 || fft_rdata !== '0) begin
            n_fail++; $display("FAIL rr_fft_quiet: got v=%b d=%h expected 0 0", fft_rvalid, fft_rdata); end
        next_cycle();
    endtask

    task automatic test_fft_write();
        fft_req = 1; fft_we = 1; fft_addr = 8'h30; fft_wdata = {4{32'hCAFE_F00D}};
        @(negedge clk);
        n_checks++; if (sram_wen !== 1'b1 || sram_ren !== 1'b0 || sram_addr !== 8'h30 || sram_wdata !== {4{32'hCAFE_F00D}}) begin
            n_fail++; $display("FAIL fw_strobe: got wen=%b ren=%b addr=%h wd=%h", sram_wen, sram_ren, sram_addr, sram_wdata); end
        n_checks++; if (sram_bweb !== '0) begin n_fail++; $display("FAIL fw_bweb: got %h expected 0", sram_bweb); end
        next_cycle();
        fft_we = 0;
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_checks++; if (fft_rvalid !== 1'b1 || fft_rdata !== {4{32'hCAFE_F00D}}) begin
            n_fail++; $display("FAIL fw_readback: got v=%b d=%h expected 1 %h", fft_rvalid, fft_rdata, {4{32'hCAFE_F00D}}); end
        next_cycle();
    endtask

    task automatic test_saturation_reset();
        conflict_clr = 1;
        next_cycle();
        conflict_clr = 0;
        scan_req = 1; fft_req = 1; scan_addr = 8'h50; fft_addr = 8'h51;
        repeat (20) next_cycle();
        drive_idle();
        @(negedge clk);
        n_checks++; if (conflict_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_cnt: got %h expected F", conflict_cnt); end
        next_cycle();
        scan_req = 1; fft_req = 1; conflict_clr = 1;
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_checks++; if (conflict_cnt !== 4'h0) begin n_fail++; $display("FAIL clr_prio: got %h expected 0", conflict_cnt); end
        next_cycle();
        scan_req = 1; fft_req = 1;
        repeat (3) next_cycle();
        drive_idle();
        @(negedge clk);
        n_checks++; if (conflict_cnt !== 4'h3) begin n_fail++; $display("FAIL pre_rst_cnt: got %h expected 3", conflict_cnt); end
        next_cycle();
        scan_req = 1; scan_addr = 8'h05;
        @(negedge clk);
        n_checks++; if (scan_gnt !== 1'b1 || sram_ren !== 1'b1) begin
            n_fail++; $display("FAIL pre_rst_read: got g=%b ren=%b expected 1 1", scan_gnt, sram_ren); end
        next_cycle();
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (scan_rvalid !== 1'b0 || fft_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rst_drop: got s=%b f=%b expected 0 0", scan_rvalid, fft_rvalid); end
        n_checks++; if (conflict_cnt !== 4'h0) begin n_fail++; $display("FAIL rst_cnt_clear: got %h expected 0", conflict_cnt); end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (scan_rvalid !== 1'b0 || fft_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rst_no_reassert: got s=%b f=%b expected 0 0", scan_rvalid, fft_rvalid); end
        next_cycle();
        scan_req = 1; fft_req = 1;
        @(negedge clk);
        n_checks++; if (scan_gnt !== 1'b1 || fft_gnt !== 1'b0) begin
            n_fail++; $display("FAIL rst_first_conflict: got s=%b f=%b expected s=1 f=0", scan_gnt, fft_gnt); end
        next_cycle();
        drive_idle();
        next_cycle();
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;
        test_reset();
        test_scan_write_read();
        test_fairness();
        test_lock();
        test_read_routing();
        test_fft_write();
        test_saturation_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sram_port_arbiter
`default_nettype wire
